// File: rtl/clock_pkg.sv
// Shared calendar definitions for the timekeeper and its set controller.
// Holds the edit FSM states, field limits and month lengths.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_MON    = 3'd1,
    ST_DAY    = 3'd2,
    ST_HRS    = 3'd3,
    ST_MIN    = 3'd4,
    ST_COMMIT = 3'd5
  } state_t;

  localparam logic [3:0] MON_MAX = 4'd12;
  localparam logic [4:0] HRS_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  function automatic logic [4:0] days_in_month(
    input logic [3:0] mon,
    input logic       leap
  );
    logic [4:0] dim;
    case (mon)
      4'd1, 4'd3, 4'd5, 4'd7,
      4'd8, 4'd10, 4'd12: dim = 5'd31;
      4'd4, 4'd6,
      4'd9, 4'd11:        dim = 5'd30;
      4'd2:    dim = leap ? 5'd29 : 5'd28;
      default: dim = 5'd28;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registers a synchronised button level.
// Emits a one-cycle pulse on its rising edge.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic btn_q;
  logic btn_d;

  assign btn_d = btn;

  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn_d;
  end

  assign pulse = btn & ~btn_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Two-button field editor for the calendar timekeeper.
// Freezes the count while editing, commits with a one-cycle load.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       leap,
  input  logic [3:0] cur_mon,
  input  logic [4:0] cur_day,
  input  logic [4:0] cur_hrs,
  input  logic [5:0] cur_min,
  output logic       run_en,
  output logic       load,
  output logic [3:0] ld_mon,
  output logic [4:0] ld_day,
  output logic [4:0] ld_hrs,
  output logic [5:0] ld_min,
  output logic [5:0] ld_sec,
  output logic [2:0] edit_field
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  logic mode_e;
  logic inc_e;

  btn_edge u_mode (
    .clk   (clk),
    .rst   (rst),
    .btn   (mode_btn),
    .pulse (mode_e)
  );

  btn_edge u_inc (
    .clk   (clk),
    .rst   (rst),
    .btn   (inc_btn),
    .pulse (inc_e)
  );

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [3:0]      mon_q, mon_d;
  logic [4:0]      day_q, day_d;
  logic [4:0]      hrs_q, hrs_d;
  logic [5:0]      min_q, min_d;
  logic [4:0]      dim;
  logic [4:0]      day_clamp;

  assign dim       = days_in_month(mon_q, leap);
  assign day_clamp = (day_q > dim) ? dim : day_q;

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    mon_d   = mon_q;
    day_d   = day_q;
    hrs_d   = hrs_q;
    min_d   = min_q;
    unique case (state_q)
      ST_RUN: begin
        to_d = '0;
        if (mode_e) begin
          state_d = ST_MON;
          mon_d   = cur_mon;
          day_d   = cur_day;
          hrs_d   = cur_hrs;
          min_d   = cur_min;
        end
      end
      ST_MON, ST_DAY, ST_HRS, ST_MIN: begin
        if (to_q == TO_MAX) begin
          state_d = ST_RUN;
          to_d    = '0;
        end else if (mode_e) begin
          // mode wins over a coincident inc edge
          to_d = '0;
          unique case (state_q)
            ST_MON: begin
              state_d = ST_DAY;
              day_d   = day_clamp;
            end
            ST_DAY: state_d = ST_HRS;
            ST_HRS: state_d = ST_MIN;
            default: begin
              state_d = ST_COMMIT;
              day_d   = day_clamp;
            end
          endcase
        end else if (inc_e) begin
          to_d = '0;
          unique case (state_q)
            ST_MON:
              mon_d = (mon_q >= MON_MAX) ? 4'd1 : mon_q + 4'd1;
            ST_DAY:
              day_d = (day_q >= dim) ? 5'd1 : day_q + 5'd1;
            ST_HRS:
              hrs_d = (hrs_q >= HRS_MAX) ? 5'd0 : hrs_q + 5'd1;
            default:
              min_d = (min_q >= MIN_MAX) ? 6'd0 : min_q + 6'd1;
          endcase
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_COMMIT: begin
        state_d = ST_RUN;
        to_d    = '0;
      end
      default: begin
        state_d = ST_RUN;
        to_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      to_q    <= '0;
      mon_q   <= 4'd1;
      day_q   <= 5'd1;
      hrs_q   <= 5'd0;
      min_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      mon_q   <= mon_d;
      day_q   <= day_d;
      hrs_q   <= hrs_d;
      min_q   <= min_d;
    end
  end

  assign run_en = (state_q == ST_RUN);
  assign load   = (state_q == ST_COMMIT);
  assign ld_mon = mon_q;
  assign ld_day = day_q;
  assign ld_hrs = hrs_q;
  assign ld_min = min_q;
  assign ld_sec = 6'd0;

  always_comb begin
    edit_field = 3'd0;
    unique case (state_q)
      ST_MON:  edit_field = 3'd1;
      ST_DAY:  edit_field = 3'd2;
      ST_HRS:  edit_field = 3'd3;
      ST_MIN:  edit_field = 3'd4;
      default: edit_field = 3'd0;
    endcase
  end

endmodule
